// File: rtl/display_mem_pkg.sv
// Shared constants, FSM state type and the y/x -> bank/address map of the banked display memory.
package display_mem_pkg;

  localparam int unsigned NO_BANKS       = 8;
  localparam int unsigned COORDW         = 10;
  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned GROUPS         = 8;
  localparam int unsigned DISPLAY_W      = 512;
  localparam int unsigned MAG_W          = 10;
  localparam int unsigned H              = NO_BANKS * GROUPS * DATA_W;
  localparam int unsigned WORDS          = NO_BANKS * GROUPS;
  localparam int unsigned K_W            = 6;
  localparam int unsigned X_W            = 9;
  localparam int unsigned ROW_W          = COORDW - 3;
  localparam int unsigned THR_W          = MAG_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NO_BANKS-1:0]       bank_select;
    logic [RAM_ADDR_WIDTH-1:0] address;
  } bank_addr_t;

  // row_word is y[9:3]: the pixel row within a word (y[2:0]) never affects the location.
  // Rows beyond the last bank select no bank at all.
  function automatic bank_addr_t word_to_bank_addr(input logic [ROW_W-1:0]  row_word,
                                                   input logic [COORDW-1:0] x);
    bank_addr_t r;
    r.bank_select = row_word[ROW_W-1] ? '0 : (NO_BANKS'(1) << row_word[ROW_W-2:3]);
    r.address     = RAM_ADDR_WIDTH'({row_word[2:0], 9'b0}) + RAM_ADDR_WIDTH'(x);
    return r;
  endfunction

endpackage

// File: rtl/bank_addr_encode.sv
// Combinational word-row/column -> one-hot bank select and in-bank word address.
module bank_addr_encode
  import display_mem_pkg::*;
(
  input  logic [ROW_W-1:0]          i_row_word,
  input  logic [COORDW-1:0]         i_x,
  output logic [NO_BANKS-1:0]       o_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0] o_address
);

  bank_addr_t w_loc;

  // Same mapping function as the display read path.
  always_comb begin
    w_loc         = word_to_bank_addr(i_row_word, i_x);
    o_bank_select = w_loc.bank_select;
    o_address     = w_loc.address;
  end

endmodule

// File: rtl/column_bar_writer.sv
// Renders one spectrum bin as a bottom-anchored vertical bar, one 8-pixel word per granted write.
module column_bar_writer
  import display_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [COORDW-1:0]         s_x,
  input  logic [MAG_W-1:0]          s_mag,
  input  logic                      s_last,
  input  logic                      wr_grant,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      frame_done
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [K_W-1:0]            r_k;
  logic [K_W-1:0]            w_k_next;
  logic [X_W-1:0]            r_x;
  logic [X_W-1:0]            w_x_sel;
  logic [THR_W-1:0]          r_thresh;
  logic [THR_W-1:0]          w_thresh_sel;
  logic [THR_W-1:0]          w_thresh_in;
  logic [MAG_W-1:0]          w_mag_clamped;
  logic                      r_last;
  logic                      w_xfer;
  logic                      w_in_range;
  logic                      w_word_done;
  logic [DATA_W-1:0]         w_data_next;
  logic [NO_BANKS-1:0]       w_bank_sel;
  logic [RAM_ADDR_WIDTH-1:0] w_addr;

  logic                      r_s_ready;
  logic                      r_wr_en;
  logic [NO_BANKS-1:0]       r_wr_bank_select;
  logic [RAM_ADDR_WIDTH-1:0] r_wr_address;
  logic [DATA_W-1:0]         r_wr_data;
  logic                      r_busy;
  logic                      r_frame_done;

  assign s_ready        = r_s_ready;
  assign wr_en          = r_wr_en;
  assign wr_bank_select = r_wr_bank_select;
  assign wr_address     = r_wr_address;
  assign wr_data        = r_wr_data;
  assign busy           = r_busy;
  assign frame_done     = r_frame_done;

  // Handshake qualifiers and clamped threshold row (first lit row = H - mag).
  assign w_xfer        = s_valid & r_s_ready;
  assign w_in_range    = (s_x < COORDW'(DISPLAY_W));
  assign w_mag_clamped = (s_mag > MAG_W'(H)) ? MAG_W'(H) : s_mag;
  assign w_thresh_in   = THR_W'(H) - {1'b0, w_mag_clamped};
  assign w_word_done   = (r_state == ST_WRITE) & r_wr_en & wr_grant;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state plus the word counter / column operands for the word presented next cycle.
  always_comb begin
    w_next_state = r_state;
    w_k_next     = r_k;
    w_x_sel      = r_x;
    w_thresh_sel = r_thresh;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_in_range) begin
          w_next_state = ST_WRITE;
          w_k_next     = '0;
          w_x_sel      = s_x[X_W-1:0];
          w_thresh_sel = w_thresh_in;
        end
      end
      ST_WRITE: begin
        if (w_word_done) begin
          if (r_k == K_W'(WORDS - 1)) w_next_state = ST_DONE;
          else                        w_k_next     = r_k + K_W'(1);
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Pixel compare: row y_base+i is lit when it lies at or below the bar top.
  always_comb begin
    w_data_next = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      w_data_next[i] = (THR_W'({w_k_next, 3'(i)}) >= w_thresh_sel);
    end
  end

  bank_addr_encode u_bank_addr_encode (
    .i_row_word    ({1'b0, w_k_next}),
    .i_x           ({1'b0, w_x_sel}),
    .o_bank_select (w_bank_sel),
    .o_address     (w_addr)
  );

  // Latched column operands and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_x      <= '0;
      r_thresh <= '0;
      r_last   <= 1'b0;
    end else begin
      r_k      <= w_k_next;
      r_x      <= w_x_sel;
      r_thresh <= w_thresh_sel;
      if (w_xfer) r_last <= s_last;
    end
  end

  // Registered outputs; write port holds its word until granted since operands do not move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ready        <= 1'b0;
      r_wr_en          <= 1'b0;
      r_wr_bank_select <= '0;
      r_wr_address     <= '0;
      r_wr_data        <= '0;
      r_busy           <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_s_ready    <= (w_next_state == ST_IDLE);
      r_wr_en      <= (w_next_state == ST_WRITE);
      r_busy       <= (w_next_state != ST_IDLE);
      r_frame_done <= ((w_next_state == ST_DONE) & r_last) | (w_xfer & ~w_in_range & s_last);
      if (w_next_state == ST_WRITE) begin
        r_wr_bank_select <= w_bank_sel;
        r_wr_address     <= w_addr;
        r_wr_data        <= w_data_next;
      end else begin
        r_wr_bank_select <= '0;
        r_wr_address     <= '0;
        r_wr_data        <= '0;
      end
    end
  end

endmodule
